// File: rtl/nios_led_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared definitions for the OCI trace DCT packer: widths, the FSM
// encoding and the layout of the emitted {count, buffer} packet.
package nios_led_nios2_qsys_0_oci_dct_packer_pkg;

   localparam int ATOM_W = 2;               // bits per trace atom
   localparam int SLOTS  = 15;              // atoms per buffer
   localparam int CNT_W  = 4;               // fill-count width
   localparam int BUF_W  = ATOM_W * SLOTS;  // packing buffer width (30)
   localparam int PKT_W  = CNT_W + BUF_W;   // emitted packet width (34)

   // Packet field offsets: count occupies [33:30], buffer [29:0].
   localparam int PKT_CNT_LSB = BUF_W;
   localparam int PKT_CNT_MSB = PKT_W - 1;

   typedef enum logic {
      PACK = 1'b0,   // accepting atoms into the live buffer
      HOLD = 1'b1    // buffer full/flushed, waiting for the output slot
   } state_e;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic [BUF_W-1:0] buffer;
   } pkt_t;

   // Shift one atom into the right-justified buffer, newest in the LSBs.
   function automatic logic [BUF_W-1:0] shift_in(input logic [BUF_W-1:0]  buf_v,
                                                  input logic [ATOM_W-1:0] atom);
      return {buf_v[BUF_W-ATOM_W-1:0], atom};
   endfunction

endpackage

// File: rtl/nios_led_nios2_qsys_0_oci_dct_packer_if.sv
// Trace-side and packet-side signals of the DCT packer. The master modport
// is the trace source / downstream consumer view; slave is the packer view.
interface nios_led_nios2_qsys_0_oci_dct_packer_if;
   import nios_led_nios2_qsys_0_oci_dct_packer_pkg::*;

   logic              trace_enable;
   logic              atm_valid;
   logic [ATOM_W-1:0] atm_code;
   logic              flush;
   logic              clr_overflow;
   logic [BUF_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              pkt_valid;
   logic [PKT_W-1:0]  pkt_data;
   logic              pkt_ready;
   logic              overflow;

   modport master (
      output trace_enable, atm_valid, atm_code, flush, clr_overflow, pkt_ready,
      input  dct_buffer, dct_count, pkt_valid, pkt_data, overflow
   );

   modport slave (
      input  trace_enable, atm_valid, atm_code, flush, clr_overflow, pkt_ready,
      output dct_buffer, dct_count, pkt_valid, pkt_data, overflow
   );

endinterface

// File: rtl/nios_led_nios2_qsys_0_oci_pkt_reg.sv
// One-entry valid/ready output register. A new packet may load in the same
// cycle the current one is taken, so the slot is free when empty or draining.
module nios_led_nios2_qsys_0_oci_pkt_reg
   import nios_led_nios2_qsys_0_oci_dct_packer_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  pkt_t             data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [PKT_W-1:0] data_o,
   output logic             slot_free_o
);

   logic valid_q, valid_d;
   pkt_t data_q,  data_d;

   assign slot_free_o = !valid_q || ready_i;
   assign valid_o     = valid_q;
   assign data_o      = data_q;

   // Next-state: load wins over drain; data only changes on a load.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Output register state.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/nios_led_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into a 30-bit DCT buffer with a fill count and
// emits {count, buffer} packets when the buffer fills or on a flush.
module nios_led_nios2_qsys_0_oci_dct_packer
   import nios_led_nios2_qsys_0_oci_dct_packer_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   nios_led_nios2_qsys_0_oci_dct_packer_if.slave dct
);

   if (SLOTS >= (1 << CNT_W)) begin : g_bad_slots
      $error("SLOTS must be less than 2**CNT_W");
   end
   if (BUF_W != ATOM_W * SLOTS) begin : g_bad_buf
      $error("BUF_W must equal ATOM_W*SLOTS");
   end

   state_e           state_q, state_d;
   logic [BUF_W-1:0] buf_q,   buf_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             ovf_q,   ovf_d;

   logic             accept;
   logic [BUF_W-1:0] new_buf;
   logic [CNT_W-1:0] new_cnt;
   logic             emit;
   logic             drop;
   logic             load;
   pkt_t             load_pkt;
   logic             slot_free;

   assign dct.dct_buffer = buf_q;
   assign dct.dct_count  = cnt_q;
   assign dct.overflow   = ovf_q;

   nios_led_nios2_qsys_0_oci_pkt_reg u_pkt_reg (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (load),
      .data_i      (load_pkt),
      .ready_i     (dct.pkt_ready),
      .valid_o     (dct.pkt_valid),
      .data_o      (dct.pkt_data),
      .slot_free_o (slot_free)
   );

   // Packer FSM next-state, buffer update, packet load and overflow tracking.
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      load     = 1'b0;
      load_pkt = '0;
      drop     = 1'b0;
      accept   = dct.atm_valid && dct.trace_enable;
      // Post-atom view: an atom arriving with a flush is packed first.
      new_buf  = accept ? shift_in(buf_q, dct.atm_code) : buf_q;
      new_cnt  = accept ? cnt_q + CNT_W'(1) : cnt_q;
      emit     = (accept && (new_cnt == CNT_W'(SLOTS)))
              || (dct.flush && (new_cnt != '0));

      case (state_q)
         PACK: begin
            buf_d = new_buf;
            cnt_d = new_cnt;
            if (emit) begin
               if (slot_free) begin
                  load           = 1'b1;
                  load_pkt.count  = new_cnt;
                  load_pkt.buffer = new_buf;
                  buf_d          = '0;
                  cnt_d          = '0;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Buffer is frozen; a flush here is covered by the pending emit.
            drop = accept;
            if (slot_free) begin
               load           = 1'b1;
               load_pkt.count  = cnt_q;
               load_pkt.buffer = buf_q;
               buf_d          = '0;
               cnt_d          = '0;
               state_d        = PACK;
            end
         end
         default: state_d = PACK;
      endcase

      // Sticky overflow: a drop in the same cycle as a clear keeps it set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (dct.clr_overflow) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Packer state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PACK;
         buf_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_nios_led_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer: stimulus pushes expected packets into
// a queue, a monitor pops and compares each packet the DUT hands over.
module tb_nios_led_nios2_qsys_0_oci_dct_packer;
   import nios_led_nios2_qsys_0_oci_dct_packer_pkg::*;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;
   pkt_t exp_q[$];

   nios_led_nios2_qsys_0_oci_dct_packer_if dct_if ();

   nios_led_nios2_qsys_0_oci_dct_packer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .dct     (dct_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] code, input logic fl);
      dct_if.atm_valid = 1'b1;
      dct_if.atm_code  = code;
      dct_if.flush     = fl;
      tick();
      dct_if.atm_valid = 1'b0;
      dct_if.flush     = 1'b0;
   endtask

   task automatic push(input logic [3:0] cnt, input logic [29:0] bufv);
      pkt_t p;
      p.count  = cnt;
      p.buffer = bufv;
      exp_q.push_back(p);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_buf"},   64'(dct_if.dct_buffer), 64'd0);
      check({tag, "_cnt"},   64'(dct_if.dct_count),  64'd0);
      check({tag, "_valid"}, 64'(dct_if.pkt_valid),  64'd0);
      check({tag, "_data"},  64'(dct_if.pkt_data),   64'd0);
      check({tag, "_ovf"},   64'(dct_if.overflow),   64'd0);
   endtask

   // Monitor: a handshake seen at the falling edge completes on the next rise.
   always @(negedge clk) begin
      if (reset_n && dct_if.pkt_valid && dct_if.pkt_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pkt", 64'(dct_if.pkt_data), 64'd0);
         end else begin
            check("pkt_data", 64'(dct_if.pkt_data), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      dct_if.trace_enable = 1'b1;
      dct_if.atm_valid    = 1'b0;
      dct_if.atm_code     = '0;
      dct_if.flush        = 1'b0;
      dct_if.clr_overflow = 1'b0;
      dct_if.pkt_ready    = 1'b1;
      #3;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Full buffer of codes 0,1,2,3,... emits immediately with ready high.
      for (int i = 0; i < 14; i++) send(2'(i % 4), 1'b0);
      check("fill14_cnt", 64'(dct_if.dct_count), 64'd14);
      push(4'hF, 30'h06C6C6C6);
      send(2'd2, 1'b0);
      check("fill15_valid", 64'(dct_if.pkt_valid), 64'd1);
      check("fill15_cnt",   64'(dct_if.dct_count), 64'd0);
      tick();

      // Partial buffer flush.
      for (int i = 0; i < 3; i++) send(2'b11, 1'b0);
      push(4'd3, 30'h3F);
      dct_if.flush = 1'b1;
      tick();
      dct_if.flush = 1'b0;
      check("flush_valid", 64'(dct_if.pkt_valid), 64'd1);
      tick();
      check("flush_valid_1cyc", 64'(dct_if.pkt_valid), 64'd0);

      // Flush on an empty buffer does nothing.
      dct_if.flush = 1'b1;
      tick();
      dct_if.flush = 1'b0;
      check("empty_flush_valid", 64'(dct_if.pkt_valid), 64'd0);
      check("empty_flush_cnt",   64'(dct_if.dct_count), 64'd0);

      // Atoms ignored while tracing is disabled.
      dct_if.trace_enable = 1'b0;
      for (int i = 0; i < 5; i++) send(2'(i % 4), 1'b0);
      check("disabled_cnt", 64'(dct_if.dct_count), 64'd0);
      check("disabled_ovf", 64'(dct_if.overflow),  64'd0);

      // Flush still emits with tracing disabled; the simultaneous atom is ignored.
      dct_if.trace_enable = 1'b1;
      send(2'd1, 1'b0);
      send(2'd2, 1'b0);
      check("two_atoms_buf", 64'(dct_if.dct_buffer), 64'h6);
      dct_if.trace_enable = 1'b0;
      push(4'd2, 30'h6);
      send(2'd3, 1'b1);
      dct_if.trace_enable = 1'b1;
      check("dis_flush_valid", 64'(dct_if.pkt_valid), 64'd1);
      check("dis_flush_cnt",   64'(dct_if.dct_count), 64'd0);
      tick();

      // Back-pressure: one pending packet, a second buffer fills into HOLD.
      dct_if.pkt_ready = 1'b0;
      push(4'd1, 30'h1);
      send(2'd1, 1'b1);
      check("pend_valid", 64'(dct_if.pkt_valid), 64'd1);
      for (int i = 0; i < 15; i++) send(2'b11, 1'b0);
      push(4'hF, 30'h3FFFFFFF);
      check("hold_cnt", 64'(dct_if.dct_count),  64'd15);
      check("hold_buf", 64'(dct_if.dct_buffer), 64'h3FFFFFFF);
      check("hold_ovf", 64'(dct_if.overflow),   64'd0);
      check("hold_pkt_stable", 64'(dct_if.pkt_data), {30'd0, 4'd1, 30'h1});
      dct_if.clr_overflow = 1'b1;
      send(2'd0, 1'b0);
      dct_if.clr_overflow = 1'b0;
      check("ovf_set_wins", 64'(dct_if.overflow),   64'd1);
      check("hold_frozen",  64'(dct_if.dct_buffer), 64'h3FFFFFFF);
      dct_if.clr_overflow = 1'b1;
      tick();
      dct_if.clr_overflow = 1'b0;
      check("ovf_cleared", 64'(dct_if.overflow), 64'd0);
      send(2'd2, 1'b0);
      check("ovf_again", 64'(dct_if.overflow), 64'd1);
      dct_if.flush = 1'b1;
      tick();
      dct_if.flush = 1'b0;
      check("hold_flush_cnt", 64'(dct_if.dct_count), 64'd15);
      dct_if.pkt_ready = 1'b1;
      tick();
      check("drain_valid", 64'(dct_if.pkt_valid), 64'd1);
      check("drain_cnt",   64'(dct_if.dct_count), 64'd0);
      tick();
      check("drain_done", 64'(dct_if.pkt_valid), 64'd0);
      dct_if.clr_overflow = 1'b1;
      tick();
      dct_if.clr_overflow = 1'b0;

      // Asynchronous reset mid-packing.
      for (int i = 0; i < 7; i++) send(2'(i % 4), 1'b0);
      check("mid_cnt", 64'(dct_if.dct_count), 64'd7);
      reset_n = 1'b0;
      #1;
      check_all_zero("rst_pack");
      #2;
      reset_n = 1'b1;
      send(2'd2, 1'b0);
      send(2'd1, 1'b0);
      check("resume_cnt", 64'(dct_if.dct_count),  64'd2);
      check("resume_buf", 64'(dct_if.dct_buffer), 64'h9);

      // Asynchronous reset mid-HOLD discards both packets.
      dct_if.pkt_ready = 1'b0;
      send(2'd0, 1'b1);
      for (int i = 0; i < 15; i++) send(2'd1, 1'b0);
      check("rhold_cnt", 64'(dct_if.dct_count), 64'd15);
      reset_n = 1'b0;
      #1;
      check_all_zero("rst_hold");
      #2;
      reset_n = 1'b1;
      dct_if.pkt_ready = 1'b1;
      for (int i = 0; i < 14; i++) send(2'(i % 4), 1'b0);
      push(4'hF, 30'h06C6C6C6);
      send(2'd2, 1'b0);
      check("after_rst_valid", 64'(dct_if.pkt_valid), 64'd1);

      tick();
      tick();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
